vga_pixel_unpack: RTL and testbench
===================================

# vga_pixel_unpack

Multi-format pixel unpacker for the VGA frame path, sitting between the image-read FIFO and the low-level VGA timing generator on the pixel clock. It pulls bus words from the FIFO, splits them MSB-first into pixels of 1/2/4/8/16/32 bits, and drives RGB either through a writable palette (indexed modes) or by direct field expansion (RGB565, xRGB888). It generalises the fixed 8-bit shift-and-colormap stage with selectable depth, a programmable palette, line-aligned flushing and underflow reporting.

## Interface
- DW, 32: FIFO word width; power of two, ≥32.
- BPC, 8: bits per colour output; 1..8.
- LGPAL, 8: log2 palette entries; ≥4.

- i_clk  in  1  pixel clock; sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_mode  in  3  0:1bpp 1:2bpp 2:4bpp 3:8bpp 4:RGB565 5:xRGB888; 6,7 treated as 3.
- i_newframe  in  1  start-of-frame strobe from timing generator.
- i_newline  in  1  start-of-line strobe.
- i_rd  in  1  consume one pixel this cycle.
- i_word_valid  in  1  FIFO has a word.
- i_word  in  DW  FIFO word.
- o_word_rd  out  1  FIFO pop; word taken when i_word_valid && o_word_rd.
- i_pal_we  in  1  palette write strobe.
- i_pal_addr  in  LGPAL  palette write address.
- i_pal_data  in  3*BPC  {R,G,B} palette entry.
- o_pixel  out  3*BPC  {R,G,B}.
- o_underflow  out  1  one-cycle pulse: pixel requested with none buffered.

## Operation
- State: shift register sreg[DW-1:0], fill counter (pixels remaining, width $clog2(DW)+1), latched mode lmode.
- lmode loads i_mode only on i_newframe; mid-frame mode changes ignored.
- bpp from lmode; pixels per word = DW/bpp (DW=32: 32,16,8,4,2,1).
- o_word_rd = i_reset_n && !i_newframe && !i_newline && (fill==0 || (fill==1 && i_rd)).
- On pop: sreg←i_word, fill←DW/bpp. o_word_rd high without valid: fill←0.
- i_rd with fill>1: sreg shifts left by bpp (zero fill), fill−1.
- i_rd with fill==0: o_underflow=1 next cycle, output black for that pixel, fill stays 0.
- i_newframe or i_newline: fill←0, sreg←0 (partial word discarded; each line starts word-aligned). i_newframe beats i_newline beats i_rd.
- Head pixel = sreg[DW-1 -: bpp].
- Indexed modes: head zero-extended to LGPAL bits addresses palette; bits above LGPAL ignored.
- RGB565: R=h[15:11], G=h[10:5], B=h[4:0]; each left-justified into BPC, top bits replicated into lower bits (BPC=8: R={r,r[4:2]}).
- xRGB888: R=h[23:16], G=h[15:8], B=h[7:0], top BPC bits; h[31:24] ignored.
- When fill==0 head is treated as black (0) regardless of mode.
- Palette: 2^LGPAL×3*BPC, one write port, one registered read; simultaneous write/read same address returns old data. Contents not reset.

## Timing
- o_pixel registered: reflects head present at previous edge (1-cycle latency; palette read and direct path equalised to same latency).
- Pop-to-first-pixel: word popped at edge N is head after N; its first pixel on o_pixel after N+1.
- Back-to-back: fill==1 && i_rd with valid word gives gapless pixels across word boundary.
- Reset (async assert): sreg=0, fill=0, lmode=3, o_pixel=0, o_underflow=0, o_word_rd=0. Release synchronous to i_clk is the integrator's responsibility.
- Reset mid-line: all in-flight pixels dropped; no FIFO pop until released.

## Structure
- Package vga_pixel_pkg: mode encodings, bpp/pixels-per-word function, RGB565 expand function.
- Sub-module vga_palette_ram: 1W/1R registered-read palette RAM, parameters LGPAL, width.
- Top holds shift/fill control and format mux.

## Test plan
- 8bpp, palette[0x12]=0x112233, word 0x12345678, four i_rd -> o_pixel 0x112233 then palettes 0x34,0x56,0x78, one o_word_rd pulse.
- RGB565, word 0xF800_07E0, two i_rd -> o_pixel 0xFF0000 then 0x00FF00.
- 1bpp, palette[0]=0, [1]=0xFFFFFF, word 0x8000_0001 -> white, 30 black, white; next pop gapless on 33rd i_rd.
- i_newline after 2 of 4 pixels (8bpp) -> remaining 2 dropped, new word popped next cycle.
- Empty FIFO, i_rd -> o_pixel 0, o_underflow one cycle; i_mode changed mid-frame -> no effect until i_newframe.
- Assert i_reset_n=0 mid-word -> all outputs 0 immediately, fill 0, no pop until release.

Source files
------------

// File: rtl/vga_pixel_pkg.sv
// Shared definitions for the VGA pixel unpacker: pixel format encodings,
// depth/pixels-per-word helpers and the RGB565 channel expansion.
package vga_pixel_pkg;

  typedef enum logic [2:0] {
    MODE_1BPP    = 3'd0,
    MODE_2BPP    = 3'd1,
    MODE_4BPP    = 3'd2,
    MODE_8BPP    = 3'd3,
    MODE_RGB565  = 3'd4,
    MODE_XRGB888 = 3'd5
  } mode_e;

  // Encodings 6 and 7 are undefined and fall back to 8bpp.
  function automatic mode_e norm_mode(logic [2:0] m);
    return (m > 3'd5) ? MODE_8BPP : mode_e'(m);
  endfunction

  // The normalised encoding is log2 of the pixel depth.
  function automatic int unsigned bpp_of(mode_e m);
    return 32'd1 << m;
  endfunction

  function automatic int unsigned ppw_of(int unsigned dw, mode_e m);
    return dw >> m;
  endfunction

  function automatic logic is_indexed(mode_e m);
    return (m <= MODE_8BPP);
  endfunction

  // Left-justify each field to 8 bits, replicating its top bits downwards.
  function automatic logic [23:0] rgb565_to_888(logic [15:0] h);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = h[15:11];
    g = h[10:5];
    b = h[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// Palette RAM: one write port, one registered read port. A read of the
// address being written in the same cycle returns the previous contents.
module vga_palette_ram #(
  parameter int LGPAL = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LGPAL-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [LGPAL-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<LGPAL)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_pixel_unpack.sv
// Splits FIFO words MSB-first into pixels of 1..32 bits and maps them to RGB
// through the palette (indexed modes) or by direct field expansion.
module vga_pixel_unpack
  import vga_pixel_pkg::*;
#(
  parameter int DW    = 32,
  parameter int BPC   = 8,
  parameter int LGPAL = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [2:0]         i_mode,
  input  logic               i_newframe,
  input  logic               i_newline,
  input  logic               i_rd,
  input  logic               i_word_valid,
  input  logic [DW-1:0]      i_word,
  output logic               o_word_rd,
  input  logic               i_pal_we,
  input  logic [LGPAL-1:0]   i_pal_addr,
  input  logic [3*BPC-1:0]   i_pal_data,
  output logic [3*BPC-1:0]   o_pixel,
  output logic               o_underflow
);

  localparam int FW = $clog2(DW) + 1;
  localparam int CW = 3 * BPC;

  logic [DW-1:0] sreg;
  logic [FW-1:0] fill;
  mode_e         lmode;

  int unsigned   bpp;
  logic [FW-1:0] ppw;
  logic          fill_empty;
  logic          fill_last;
  logic [DW-1:0] head;
  logic [23:0]   rgb888;
  logic [CW-1:0] direct;
  logic [CW-1:0] direct_q;
  logic [CW-1:0] pal_rdata;
  logic          idx_q;
  logic          blank_q;

  assign bpp        = bpp_of(lmode);
  assign ppw        = FW'(ppw_of(DW, lmode));
  assign fill_empty = (fill == '0);
  assign fill_last  = (fill == FW'(1));

  // FIFO handshake: a word transfers on any edge where i_word_valid and
  // o_word_rd are both high. o_word_rd is requested whenever the buffer is
  // empty or its last pixel is being consumed, independent of i_word_valid;
  // a request without a valid word simply leaves the buffer empty.
  assign o_word_rd = i_reset_n && !i_newframe && !i_newline &&
                     (fill_empty || (fill_last && i_rd));

  assign head = fill_empty ? '0 : (sreg >> (DW - bpp));

  always_comb begin
    rgb888 = '0;
    case (lmode)
      MODE_RGB565:  rgb888 = rgb565_to_888(head[15:0]);
      MODE_XRGB888: rgb888 = head[23:0];
      default:      rgb888 = '0;
    endcase
    direct = {rgb888[23 -: BPC], rgb888[15 -: BPC], rgb888[7 -: BPC]};
  end

  vga_palette_ram #(
    .LGPAL (LGPAL),
    .WIDTH (CW)
  ) u_palette (
    .clk   (i_clk),
    .we    (i_pal_we),
    .waddr (i_pal_addr),
    .wdata (i_pal_data),
    .raddr (head[LGPAL-1:0]),
    .rdata (pal_rdata)
  );

  // Direct colour and select flags are registered alongside the palette read
  // so both paths present the same one-cycle latency.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sreg        <= '0;
      fill        <= '0;
      lmode       <= MODE_8BPP;
      direct_q    <= '0;
      idx_q       <= 1'b0;
      blank_q     <= 1'b1;
      o_underflow <= 1'b0;
    end else begin
      direct_q    <= direct;
      idx_q       <= is_indexed(lmode);
      blank_q     <= fill_empty;
      o_underflow <= i_rd && fill_empty && !i_newframe && !i_newline;
      if (i_newframe) begin
        lmode <= norm_mode(i_mode);
        fill  <= '0;
        sreg  <= '0;
      end else if (i_newline) begin
        fill <= '0;
        sreg <= '0;
      end else if (o_word_rd) begin
        if (i_word_valid) begin
          sreg <= i_word;
          fill <= ppw;
        end else begin
          sreg <= '0;
          fill <= '0;
        end
      end else if (i_rd && (fill > FW'(1))) begin
        sreg <= sreg << bpp;
        fill <= fill - FW'(1);
      end
    end
  end

  assign o_pixel = blank_q ? '0 : (idx_q ? pal_rdata : direct_q);

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Self-checking bench for vga_pixel_unpack: directed vector table, hand-built
// corner sequences and a randomized run against a pixel-queue reference model.
module tb_vga_pixel_unpack;

  localparam int DW    = 32;
  localparam int BPC   = 8;
  localparam int LGPAL = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  mode;
  logic        nf, nl, rd, wv;
  logic [31:0] word;
  logic        word_rd;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data;
  logic [23:0] pixel;
  logic        underflow;

  vga_pixel_unpack #(.DW(DW), .BPC(BPC), .LGPAL(LGPAL)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_mode       (mode),
    .i_newframe   (nf),
    .i_newline    (nl),
    .i_rd         (rd),
    .i_word_valid (wv),
    .i_word       (word),
    .o_word_rd    (word_rd),
    .i_pal_we     (pal_we),
    .i_pal_addr   (pal_addr),
    .i_pal_data   (pal_data),
    .o_pixel      (pixel),
    .o_underflow  (underflow)
  );

  // scoreboard / reference model
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mode_m;
  logic [31:0] exp_q[$];
  logic [23:0] pal_m [0:255];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] color(logic [31:0] p);
    int r, g, b;
    if (mode_m == 4) begin
      r = int'((p >> 11) & 31);
      g = int'((p >> 5) & 63);
      b = int'(p & 31);
      return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    end else if (mode_m == 5) begin
      return p[23:0];
    end
    return pal_m[p % 256];
  endfunction

  task automatic load_word(logic [31:0] w);
    int bpp;
    bpp = 1 << mode_m;
    for (int i = 0; i < 32 / bpp; i++)
      exp_q.push_back(32'((64'(w) >> (32 - bpp * (i + 1))) & ((64'd1 << bpp) - 1)));
  endtask

  // driver: inputs already set by caller; checks handshake, advances one edge
  task automatic cycle();
    logic [23:0] ep;
    logic        eu, ewr;
    int          sz;
    #1;
    sz  = exp_q.size();
    ewr = rst_n && !nf && !nl && (sz == 0 || (sz == 1 && rd));
    check("word_rd", 32'(word_rd), 32'(ewr));
    if (!rst_n) begin
      ep = '0;
      eu = 1'b0;
    end else begin
      ep = (sz > 0) ? color(exp_q[0]) : 24'd0;
      eu = rd && sz == 0 && !nf && !nl;
    end
    @(posedge clk);
    if (rst_n) begin
      if (nf) begin
        mode_m = (mode > 3'd5) ? 3 : int'(mode);
        exp_q.delete();
      end else if (nl) begin
        exp_q.delete();
      end else if (ewr) begin
        exp_q.delete();
        if (wv) load_word(word);
      end else if (rd && sz > 1) begin
        void'(exp_q.pop_front());
      end
    end
    if (pal_we) pal_m[pal_addr] = pal_data;
    #1;
    check("pixel", 32'(pixel), 32'(ep));
    check("underflow", 32'(underflow), 32'(eu));
  endtask

  task automatic idle();
    nf = 0; nl = 0; rd = 0; wv = 0; pal_we = 0;
  endtask

  task automatic pal_write(int a, logic [23:0] d);
    pal_we = 1; pal_addr = 8'(a); pal_data = d;
    cycle();
    pal_we = 0;
  endtask

  task automatic start_frame(logic [2:0] m);
    nf = 1; mode = m;
    cycle();
    nf = 0;
  endtask

  task automatic push_word(logic [31:0] w);
    wv = 1; word = w;
    cycle();
    wv = 0;
  endtask

  typedef struct {
    logic [2:0]       mode;
    logic [31:0]      word;
    int               n;
    logic [3:0][23:0] exp;   // exp[0] is the first pixel
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{3'd3, 32'h1234_5678, 4, {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233}};
    vecs[1] = '{3'd4, 32'hF800_07E0, 2, {24'h0, 24'h0, 24'h00FF00, 24'hFF0000}};
    vecs[2] = '{3'd5, 32'hFF10_2030, 1, {24'h0, 24'h0, 24'h0, 24'h102030}};
    vecs[3] = '{3'd4, 32'h001F_8410, 2, {24'h0, 24'h0, 24'h848284, 24'h0000FF}};
    vecs[4] = '{3'd2, 32'h0F00_0000, 2, {24'h0, 24'h0, 24'h0F0F0F, 24'h000000}};
    vecs[5] = '{3'd1, 32'h4000_0000, 2, {24'h0, 24'h0, 24'h000000, 24'hFFFFFF}};
    vecs[6] = '{3'd7, 32'h3412_0000, 2, {24'h0, 24'h0, 24'h112233, 24'h445566}};

    rst_n = 0; idle(); mode = 0; word = '0; pal_addr = '0; pal_data = '0;
    mode_m = 3; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset pixel", 32'(pixel), 32'h0);
    check("reset underflow", 32'(underflow), 32'h0);
    check("reset word_rd", 32'(word_rd), 32'h0);
    rst_n = 1;

    for (int a = 0; a < 256; a++) pal_write(a, 24'($urandom));
    pal_write(8'h00, 24'h000000);
    pal_write(8'h01, 24'hFFFFFF);
    pal_write(8'h0F, 24'h0F0F0F);
    pal_write(8'h12, 24'h112233);
    pal_write(8'h34, 24'h445566);
    pal_write(8'h56, 24'h778899);
    pal_write(8'h78, 24'hAABBCC);

    // vector table
    for (int v = 0; v < NV; v++) begin
      start_frame(vecs[v].mode);
      push_word(vecs[v].word);
      for (int k = 0; k < vecs[v].n; k++) begin
        rd = 1;
        cycle();
        check($sformatf("vec%0d pixel%0d", v, k), 32'(pixel), 32'(vecs[v].exp[k]));
      end
      rd = 0;
      cycle();
    end

    // 1bpp: white, 30 black, white, then gapless refill
    start_frame(3'd0);
    push_word(32'h8000_0001);
    for (int k = 0; k < 32; k++) begin
      rd = 1;
      if (k == 31) begin
        wv = 1; word = 32'h8000_0000;
        #1;
        check("gapless pop request", 32'(word_rd), 32'h1);
      end
      cycle();
      check($sformatf("1bpp pixel%0d", k), 32'(pixel),
            (k == 0 || k == 31) ? 32'hFFFFFF : 32'h0);
    end
    wv = 0;
    cycle();
    check("1bpp pixel32 gapless", 32'(pixel), 32'hFFFFFF);
    rd = 0;
    cycle();

    // newline drops the rest of the word
    start_frame(3'd3);
    push_word(32'h1234_5678);
    rd = 1; cycle(); cycle(); rd = 0;
    nl = 1; wv = 1; word = 32'h9999_9999;
    #1;
    check("newline blocks pop", 32'(word_rd), 32'h0);
    cycle();
    nl = 0; word = 32'h7856_3412;
    #1;
    check("pop after newline", 32'(word_rd), 32'h1);
    cycle();
    wv = 0; rd = 1;
    cycle();
    check("first pixel after newline", 32'(pixel), 32'hAABBCC);
    rd = 0;

    // underflow on empty buffer
    nl = 1; cycle(); nl = 0;
    rd = 1; cycle();
    check("underflow pulse", 32'(underflow), 32'h1);
    check("underflow black", 32'(pixel), 32'h0);
    rd = 0; cycle();
    check("underflow clears", 32'(underflow), 32'h0);

    // mode change without newframe is ignored
    mode = 3'd4;
    push_word(32'h1234_5678);
    rd = 1; cycle();
    check("mid-frame mode ignored", 32'(pixel), 32'h112233);
    rd = 0; cycle();

    // randomized run
    for (int c = 0; c < 3000; c++) begin
      nf = (c % 250 == 0) || ($urandom_range(0, 299) == 0);
      mode = (c % 250 == 0) ? 3'((c / 250) % 8) : 3'($urandom_range(0, 7));
      nl = ($urandom_range(0, 79) == 0);
      rd = ($urandom_range(0, 9) < 7);
      wv = ($urandom_range(0, 9) < 6);
      word = $urandom;
      pal_we = ($urandom_range(0, 19) == 0);
      pal_addr = 8'($urandom);
      pal_data = 24'($urandom);
      cycle();
    end
    idle();
    cycle();

    // asynchronous reset in the middle of a word
    pal_write(8'h12, 24'h112233);
    start_frame(3'd3);
    push_word(32'h1234_5678);
    rd = 1; cycle(); rd = 0;
    wv = 1; word = 32'h1200_0000;
    #2;
    rst_n = 0;
    exp_q.delete();
    mode_m = 3;
    #1;
    check("async reset pixel", 32'(pixel), 32'h0);
    check("async reset underflow", 32'(underflow), 32'h0);
    check("async reset word_rd", 32'(word_rd), 32'h0);
    cycle();
    cycle();
    rst_n = 1;
    cycle();
    wv = 0; rd = 1;
    cycle();
    check("pixel after reset", 32'(pixel), 32'h112233);
    rd = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
